// File: rtl/l1_req_arb.sv
// l1_req_arb
// Arbitrates L1I and L1D miss/uncached requests onto the single request port
// of the L1 memory access unit (MAU). The MAU accepts one transaction at a
// time and detects a new request on the rising edge of mau_req_val, so this
// block serialises the two requesters and inserts a one-cycle val-low gap
// after every transaction. D has priority, except that a starvation counter
// forces an I grant after STARVE_MAX consecutive D grants over a pending I.
//
// Ports:
//   wb_clk_i, rst_n     clock, asynchronous active-low reset
//   l1i_req_*           I requester: level val held until l1i_req_ack, line address
//   l1i_req_ack/_data   one-cycle completion pulse to I with returned line
//   l1d_req_*           D requester: val, nc, we, addr, wdata, be
//   l1d_req_ack/_data   one-cycle completion pulse to D with returned line
//   mau_req_*           registered request towards the MAU
//   mau_req_ack/_data   MAU completion pulse and line data
//   arb_busy            a transaction or its trailing gap is in progress
//   arb_owner           0 = I, 1 = D; current or most recent grant
module l1_req_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BE_W       = 4,
   parameter int LINE_W     = 128,
   parameter int STARVE_MAX = 4
) (
   input  logic              wb_clk_i,
   input  logic              rst_n,

   input  logic              l1i_req_val,
   input  logic [ADDR_W-1:0] l1i_req_addr,
   output logic              l1i_req_ack,
   output logic [LINE_W-1:0] l1i_ack_data,

   input  logic              l1d_req_val,
   input  logic              l1d_req_nc,
   input  logic              l1d_req_we,
   input  logic [ADDR_W-1:0] l1d_req_addr,
   input  logic [DATA_W-1:0] l1d_req_wdata,
   input  logic [BE_W-1:0]   l1d_req_be,
   output logic              l1d_req_ack,
   output logic [LINE_W-1:0] l1d_ack_data,

   output logic              mau_req_val,
   output logic              mau_req_nc,
   output logic              mau_req_we,
   output logic [ADDR_W-1:0] mau_req_addr,
   output logic [DATA_W-1:0] mau_req_wdata,
   output logic [BE_W-1:0]   mau_req_be,
   input  logic              mau_req_ack,
   input  logic [LINE_W-1:0] mau_ack_data,

   output logic              arb_busy,
   output logic              arb_owner
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] starve_cnt;
   logic             grant;
   logic             grant_i;
   logic             txn_ack;

   // Winner selection: grants are only issued from IDLE. I wins when it is the
   // only requester or when D has already won STARVE_MAX times over it.
   always_comb begin
      grant   = (state == IDLE) && (l1i_req_val || l1d_req_val);
      grant_i = l1i_req_val && (!l1d_req_val || (starve_cnt == STARVE_LIM));
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // GAP always lasts exactly one cycle so the MAU sees val low between
   // transactions and can detect the next rising edge.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant) next_state = REQ;
         REQ:     if (mau_req_ack) next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered MAU request. Fields are captured only on a grant and then held
   // through REQ; val tracks entry into REQ so it drops on the ack edge.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         mau_req_val   <= 1'b0;
         mau_req_nc    <= 1'b0;
         mau_req_we    <= 1'b0;
         mau_req_addr  <= '0;
         mau_req_wdata <= '0;
         mau_req_be    <= '0;
         arb_owner     <= 1'b0;
      end else begin
         mau_req_val <= (next_state == REQ);
         if (grant) begin
            arb_owner <= !grant_i;
            if (grant_i) begin
               mau_req_nc    <= 1'b0;
               mau_req_we    <= 1'b0;
               mau_req_addr  <= l1i_req_addr;
               mau_req_wdata <= '0;
               mau_req_be    <= '1;
            end else begin
               mau_req_nc    <= l1d_req_nc;
               mau_req_we    <= l1d_req_we;
               mau_req_addr  <= l1d_req_addr;
               mau_req_wdata <= l1d_req_wdata;
               mau_req_be    <= l1d_req_be;
            end
         end
      end
   end

   // Starvation counter: counts D grants taken while I was waiting, saturating
   // at the limit; any I grant clears it.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (grant_i) begin
            starve_cnt <= '0;
         end else if (l1i_req_val && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

   // Acks are only honoured in REQ; a stray MAU ack in IDLE or GAP is dropped.
   always_comb begin
      txn_ack      = (state == REQ) && mau_req_ack;
      l1i_req_ack  = txn_ack && !arb_owner;
      l1d_req_ack  = txn_ack && arb_owner;
      l1i_ack_data = l1i_req_ack ? mau_ack_data : '0;
      l1d_ack_data = l1d_req_ack ? mau_ack_data : '0;
      arb_busy     = (state != IDLE);
   end

endmodule

// File: tb/tb_l1_req_arb.sv
// tb_l1_req_arb
// Randomised bench for l1_req_arb. A transaction-level reference model inside
// the stimulus process decides grants from the arbitration rules and pushes
// expected MAU requests and requester acks into queues; an independent monitor
// pops and compares them whenever the DUT raises mau_req_val or an ack.
module tb_l1_req_arb;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BE_W       = 4;
   localparam int LINE_W     = 128;
   localparam int STARVE_MAX = 4;

   logic              wb_clk_i = 1'b0;
   logic              rst_n    = 1'b0;
   logic              l1i_req_val = 1'b0;
   logic [ADDR_W-1:0] l1i_req_addr = '0;
   logic              l1i_req_ack;
   logic [LINE_W-1:0] l1i_ack_data;
   logic              l1d_req_val = 1'b0;
   logic              l1d_req_nc = 1'b0;
   logic              l1d_req_we = 1'b0;
   logic [ADDR_W-1:0] l1d_req_addr = '0;
   logic [DATA_W-1:0] l1d_req_wdata = '0;
   logic [BE_W-1:0]   l1d_req_be = '0;
   logic              l1d_req_ack;
   logic [LINE_W-1:0] l1d_ack_data;
   logic              mau_req_val;
   logic              mau_req_nc;
   logic              mau_req_we;
   logic [ADDR_W-1:0] mau_req_addr;
   logic [DATA_W-1:0] mau_req_wdata;
   logic [BE_W-1:0]   mau_req_be;
   logic              mau_req_ack = 1'b0;
   logic [LINE_W-1:0] mau_ack_data = '0;
   logic              arb_busy;
   logic              arb_owner;

   l1_req_arb #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
      .LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .wb_clk_i(wb_clk_i), .rst_n(rst_n),
      .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
      .l1i_req_ack(l1i_req_ack), .l1i_ack_data(l1i_ack_data),
      .l1d_req_val(l1d_req_val), .l1d_req_nc(l1d_req_nc), .l1d_req_we(l1d_req_we),
      .l1d_req_addr(l1d_req_addr), .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be),
      .l1d_req_ack(l1d_req_ack), .l1d_ack_data(l1d_ack_data),
      .mau_req_val(mau_req_val), .mau_req_nc(mau_req_nc), .mau_req_we(mau_req_we),
      .mau_req_addr(mau_req_addr), .mau_req_wdata(mau_req_wdata), .mau_req_be(mau_req_be),
      .mau_req_ack(mau_req_ack), .mau_ack_data(mau_ack_data),
      .arb_busy(arb_busy), .arb_owner(arb_owner)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic              owner;
      logic              nc;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      int                cyc;
   } req_t;

   typedef struct {
      logic              owner;
      logic [LINE_W-1:0] data;
      int                cyc;
   } ack_t;

   req_t exp_req[$];
   ack_t exp_ack[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;
   bit mon_en   = 1'b0;
   bit prev_val = 1'b0;
   bit exp_busy = 1'b0;
   bit exp_owner = 1'b0;

   // Reference model state: one outstanding MAU transaction, earliest cycle in
   // which a new grant may be decided, and the starvation tally.
   bit busy = 1'b0;
   bit cur_owner = 1'b0;
   int req_start = 0;
   int free_at = 0;
   int starve = 0;
   int delay = 0;
   bit i_act = 1'b0, d_act = 1'b0, i_done = 1'b0, d_done = 1'b0;
   bit hold_ack = 1'b0, fixed_d = 1'b0;
   int p_i = 0, p_d = 0, p_keep = 0;

   task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cycle);
   endtask

   task automatic report_missing(input string name, input int exp_cyc);
      n_checks++;
      $display("[TB] FAIL %s: got no event, expected one at cycle %0d (now %0d)", name, exp_cyc, cycle);
   endtask

   task automatic tick();
      @(negedge wb_clk_i);
      cycle++;
   endtask

   task automatic new_i_req();
      l1i_req_val  = 1'b1;
      l1i_req_addr = {$urandom_range(32'h0FFF_FFFF), 4'h0};
      i_act = 1'b1;
   endtask

   task automatic new_d_req();
      l1d_req_val = 1'b1;
      d_act = 1'b1;
      if (fixed_d) begin
         l1d_req_nc    = 1'b1;
         l1d_req_we    = 1'b1;
         l1d_req_addr  = 32'h8000_0004;
         l1d_req_wdata = 32'hDEAD_BEEF;
         l1d_req_be    = 4'h3;
      end else begin
         l1d_req_nc    = 1'($urandom_range(1));
         l1d_req_we    = 1'($urandom_range(1));
         l1d_req_addr  = $urandom;
         l1d_req_wdata = $urandom;
         l1d_req_be    = 4'($urandom_range(15));
      end
   endtask

   // One cycle: drive requesters and the MAU, then advance the reference model.
   task automatic apply_stimulus();
      bit win_i;
      req_t r;
      ack_t a;
      tick();
      exp_busy  = busy || (cycle < free_at);
      exp_owner = cur_owner;

      if (i_done) begin
         i_done = 1'b0;
         if ($urandom_range(99) < p_keep) new_i_req();
         else begin l1i_req_val = 1'b0; i_act = 1'b0; end
      end else if (!i_act && ($urandom_range(99) < p_i)) new_i_req();

      if (d_done) begin
         d_done = 1'b0;
         if ($urandom_range(99) < p_keep) new_d_req();
         else begin l1d_req_val = 1'b0; d_act = 1'b0; end
      end else if (!d_act && ($urandom_range(99) < p_d)) new_d_req();

      mau_req_ack  = 1'b0;
      mau_ack_data = {$urandom, $urandom, $urandom, $urandom};
      if (!hold_ack) begin
         if (busy && cycle >= req_start) begin
            if (delay == 0) mau_req_ack = 1'b1;
            else delay--;
         end else if ($urandom_range(99) < 5) begin
            mau_req_ack = 1'b1;
         end
      end

      if (busy && cycle >= req_start && mau_req_ack) begin
         a.owner = cur_owner;
         a.data  = mau_ack_data;
         a.cyc   = cycle;
         exp_ack.push_back(a);
         busy    = 1'b0;
         free_at = cycle + 2;
         if (cur_owner) d_done = 1'b1;
         else i_done = 1'b1;
      end else if (!busy && cycle >= free_at && (l1i_req_val || l1d_req_val)) begin
         win_i = l1i_req_val && (!l1d_req_val || starve == STARVE_MAX);
         r.owner = !win_i;
         r.cyc   = cycle + 1;
         if (win_i) begin
            r.nc = 1'b0; r.we = 1'b0; r.addr = l1i_req_addr; r.wdata = '0; r.be = 4'hF;
            starve = 0;
         end else begin
            r.nc = l1d_req_nc; r.we = l1d_req_we; r.addr = l1d_req_addr;
            r.wdata = l1d_req_wdata; r.be = l1d_req_be;
            if (l1i_req_val && starve < STARVE_MAX) starve++;
         end
         exp_req.push_back(r);
         busy      = 1'b1;
         cur_owner = !win_i;
         req_start = cycle + 1;
         delay     = $urandom_range(4);
      end
   endtask

   task automatic run_phase(input int n, input int pi, input int pd, input int pk);
      p_i = pi; p_d = pd; p_keep = pk;
      for (int k = 0; k < n; k++) apply_stimulus();
   endtask

   task automatic drain();
      int guard;
      p_i = 0; p_d = 0; p_keep = 0;
      guard = 0;
      while ((busy || i_act || d_act || i_done || d_done) && guard < 200) begin
         apply_stimulus();
         guard++;
      end
      if (guard >= 200) report_missing("drain_timeout", cycle);
      for (int k = 0; k < 4; k++) apply_stimulus();
   endtask

   // Monitor: compares DUT activity against the expectation queues.
   always @(negedge wb_clk_i) begin
      req_t r;
      ack_t a;
      #2;
      if (mon_en) begin
         check_output("arb_busy", arb_busy, exp_busy);
         check_output("arb_owner", arb_owner, exp_owner);
         if (mau_req_val && !prev_val) begin
            if (exp_req.size() == 0) begin
               check_output("unexpected_req_val", mau_req_val, 1'b0);
            end else begin
               r = exp_req.pop_front();
               check_output("req_rise_cycle", cycle, r.cyc);
               check_output("req_nc", mau_req_nc, r.nc);
               check_output("req_we", mau_req_we, r.we);
               check_output("req_addr", mau_req_addr, r.addr);
               check_output("req_wdata", mau_req_wdata, r.wdata);
               check_output("req_be", mau_req_be, r.be);
            end
         end
         while (exp_req.size() > 0 && exp_req[0].cyc < cycle) begin
            report_missing("req_rise", exp_req[0].cyc);
            void'(exp_req.pop_front());
         end
         if (l1i_req_ack || l1d_req_ack) begin
            if (exp_ack.size() == 0) begin
               check_output("unexpected_ack", {l1i_req_ack, l1d_req_ack}, 2'b00);
            end else begin
               a = exp_ack.pop_front();
               check_output("ack_cycle", cycle, a.cyc);
               check_output("ack_i", l1i_req_ack, !a.owner);
               check_output("ack_d", l1d_req_ack, a.owner);
               check_output("ack_data_i", l1i_ack_data, a.owner ? '0 : a.data);
               check_output("ack_data_d", l1d_ack_data, a.owner ? a.data : '0);
               check_output("ack_val_held", mau_req_val, 1'b1);
            end
         end else begin
            check_output("idle_ack_data", {l1i_ack_data, l1d_ack_data}, '0);
         end
         while (exp_ack.size() > 0 && exp_ack[0].cyc < cycle) begin
            report_missing("ack_pulse", exp_ack[0].cyc);
            void'(exp_ack.pop_front());
         end
      end
      prev_val = mau_req_val;
   end

   initial begin
      $display("[TB] starting l1_req_arb bench");
      tick();
      tick();
      #1;
      check_output("rst_mau_val", mau_req_val, 1'b0);
      check_output("rst_mau_addr", mau_req_addr, '0);
      check_output("rst_mau_be", mau_req_be, '0);
      check_output("rst_busy", arb_busy, 1'b0);
      check_output("rst_owner", arb_owner, 1'b0);
      check_output("rst_ack", {l1i_req_ack, l1d_req_ack}, 2'b00);
      tick();
      rst_n   = 1'b1;
      free_at = cycle;
      mon_en  = 1'b1;

      run_phase(400, 30, 30, 30);
      run_phase(200, 100, 100, 100);
      run_phase(300, 10, 10, 0);
      run_phase(150, 100, 100, 100);
      drain();

      // Directed uncached D write, then reset while it is in REQ.
      hold_ack = 1'b1;
      fixed_d  = 1'b1;
      p_d = 100;
      apply_stimulus();
      p_d = 0;
      apply_stimulus();
      #1;
      check_output("dnc_val", mau_req_val, 1'b1);
      check_output("dnc_nc", mau_req_nc, 1'b1);
      check_output("dnc_we", mau_req_we, 1'b1);
      check_output("dnc_addr", mau_req_addr, 32'h8000_0004);
      check_output("dnc_wdata", mau_req_wdata, 32'hDEAD_BEEF);
      check_output("dnc_be", mau_req_be, 4'h3);

      tick();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      mau_req_ack = 1'b1;
      l1i_req_val = 1'b0;
      l1d_req_val = 1'b0;
      #1;
      check_output("midrst_val", mau_req_val, 1'b0);
      check_output("midrst_nc_we", {mau_req_nc, mau_req_we}, 2'b00);
      check_output("midrst_addr", mau_req_addr, '0);
      check_output("midrst_wdata", mau_req_wdata, '0);
      check_output("midrst_busy", arb_busy, 1'b0);
      check_output("midrst_owner", arb_owner, 1'b0);
      check_output("midrst_ack", {l1i_req_ack, l1d_req_ack}, 2'b00);
      check_output("midrst_ack_data", l1d_ack_data, '0);

      busy = 1'b0; starve = 0; cur_owner = 1'b0;
      i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0;
      exp_req.delete();
      exp_ack.delete();
      exp_busy = 1'b0; exp_owner = 1'b0; fixed_d = 1'b0;

      tick();
      rst_n   = 1'b1;
      free_at = cycle + 1;
      #1;
      check_output("post_rst_ack", {l1i_req_ack, l1d_req_ack}, 2'b00);
      check_output("post_rst_busy", arb_busy, 1'b0);
      mon_en   = 1'b1;
      hold_ack = 1'b0;

      run_phase(150, 100, 100, 100);
      run_phase(100, 40, 40, 20);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/l1_req_arb.md
Name: l1_req_arb

Overview:
Arbitrates L1I and L1D miss/uncached requests onto the single request port of the L1 memory access unit (MAU). The MAU supports one outstanding transaction and detects new requests on the rising edge of its val input. This block serialises the two requesters and guarantees a val-low gap between transactions. Arbitration is D-priority, with a starvation counter that forces an I grant.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, single-beat write data width
BE_W, 4, byte-enable width (DATA_W/8)
LINE_W, 128, cache line width returned on ack
STARVE_MAX, 4, consecutive D grants over a pending I before I is forced

Ports:
wb_clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
l1i_req_val  in  1  I request, level, held until l1i_req_ack
l1i_req_addr  in  ADDR_W  I line address
l1i_req_ack  out  1  one-cycle completion pulse to I
l1i_ack_data  out  LINE_W  line data, valid with l1i_req_ack
l1d_req_val  in  1  D request, level, held until l1d_req_ack
l1d_req_nc  in  1  D non-cacheable (single beat)
l1d_req_we  in  1  D write
l1d_req_addr  in  ADDR_W  D address
l1d_req_wdata  in  DATA_W  D write data
l1d_req_be  in  BE_W  D byte enables
l1d_req_ack  out  1  one-cycle completion pulse to D
l1d_ack_data  out  LINE_W  line data, valid with l1d_req_ack
mau_req_val  out  1  request to MAU, registered
mau_req_nc  out  1  registered
mau_req_we  out  1  registered
mau_req_addr  out  ADDR_W  registered
mau_req_wdata  out  DATA_W  registered
mau_req_be  out  BE_W  registered
mau_req_ack  in  1  MAU completion pulse
mau_ack_data  in  LINE_W  MAU line data
arb_busy  out  1  state != IDLE
arb_owner  out  1  0 = I, 1 = D; current or last grant

Behaviour:
- Reset: state IDLE, starve_cnt=0, arb_owner=0, and all mau_req_* outputs 0. l1i/l1d acks are 0 because they derive from state, and ack data is 0 when no ack is present. Asynchronous reset mid-transaction aborts it; the requesters must re-present, since the MAU is reset by the same system reset.
- FSM states: IDLE, REQ, GAP.
- IDLE with no val: stay in IDLE.
- IDLE, winner selection (combinational):
  - Only one val high: that requester wins.
  - Both high and starve_cnt==STARVE_MAX: I wins.
  - Both high otherwise: D wins.
- IDLE on a grant:
  - Next edge registers the winner's fields into mau_req_*, sets mau_req_val=1, sets arb_owner, and enters REQ.
  - I grant drives nc=0, we=0, be=all ones, wdata=0.
  - Latency from val high in IDLE to mau_req_val high is 1 cycle.
- Starvation counter:
  - D grant with l1i_req_val high: starve_cnt increments, saturating at STARVE_MAX.
  - I grant: starve_cnt resets to 0.
  - D grant with no I pending: starve_cnt unchanged.
- REQ:
  - mau_req_* are held stable; requester input changes are ignored.
  - On mau_req_ack, pulse l1i_req_ack or l1d_req_ack per arb_owner in the same cycle, combinationally, with *_ack_data = mau_ack_data.
  - At the same edge, clear mau_req_val and enter GAP.
  - The non-owner ack and ack_data stay 0.
- GAP: mau_req_val=0 for exactly one cycle, then IDLE. No grant is issued in GAP, which guarantees a MAU rising-edge detect per transaction. Back-to-back throughput is therefore ack → GAP → IDLE(grant) → REQ, i.e. 3 cycles from ack to the next mau_req_val.
- A requester dropping val while granted is a protocol violation. The transaction completes and the ack pulse is still delivered.
- mau_req_ack in IDLE or GAP is a protocol violation: it is ignored and no requester ack is produced.
- The owner's val still high in the cycle after its ack is treated as a new request in the next IDLE.

Test Plan:
- I only: l1i_req_val=1, addr=0x0000_1000; MAU acks after 5 cycles with data 0x...AA → mau_req_val rises 1 cycle after val with addr=0x1000, nc=0, we=0, be=0xF; l1i_req_ack pulses 1 cycle with data AA; mau_req_val=0 for ≥1 cycle.
- D uncached write: nc=1, we=1, addr=0x8000_0004, wdata=0xDEADBEEF, be=0x3 → mau_req_* carry exactly these values; only l1d_req_ack pulses.
- Simultaneous request: both vals rise in the same cycle → D is granted first, starve_cnt=1; I is granted after D's ack + GAP; starve_cnt back to 0.
- Starvation, STARVE_MAX=4: I held high while D re-requests continuously → 4 D grants, then the 5th grant goes to I even though D is pending.
- Gap check: D ack with D val kept high → mau_req_val low exactly 1 cycle in GAP, then re-asserted 1 cycle later (IDLE→REQ).
- Reset mid-REQ: rst_n low while mau_req_val=1 → all outputs 0 immediately; after release, state is IDLE, starve_cnt=0, and no spurious ack occurs.
